tgfs_serial_10bit: RTL and testbench
====================================

Name: tgfs_serial_10bit

Overview:
- Bit-serial 10-bit subtractor, D = A - B - Bin. This is the subtract/decrement counterpart to the parallel ripple-carry adder in the neuron datapath.
- Used for membrane leak and threshold-reset subtraction.
- Iterates one full-subtractor bit cell LSB-first, one bit per clock, instead of instantiating ten cells.
- Operands in and result out use valid/ready handshakes.

Parameters:
- WIDTH, 10, operand/result width in bits; legal range 2..16.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands A, B, Bin are valid
- in_ready  output  1  block can accept operands
- A  input  WIDTH  minuend
- B  input  WIDTH  subtrahend
- Bin  input  1  borrow in
- out_valid  output  1  Diff/Bout valid
- out_ready  input  1  consumer accepts result
- Diff  output  WIDTH  difference, modulo 2^WIDTH
- Bout  output  1  borrow out; 1 when A < B + Bin (unsigned)

Behaviour:
- Reset is synchronous and active-high on clk.
- While rst is sampled high: state=IDLE, bit counter=0, shift registers=0, borrow register=0.
- Reset values: Diff=0, Bout=0, out_valid=0.
- in_ready = (state==IDLE) && !rst.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - On an edge with in_valid && in_ready: latch A and B into shift registers, borrow=Bin, cnt=0, go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT, each edge:
  - d = a0 ^ b0 ^ borrow.
  - borrow_next = (~a0 & b0) | (~(a0 ^ b0) & borrow), where a0/b0 are the current LSBs.
  - Shift d into the result MSB side; shift the A/B registers right.
  - cnt++.
  - On the edge where cnt==WIDTH-1: go to DONE and load Diff/Bout from the final result and borrow.
- DONE:
  - out_valid=1.
  - Diff and Bout are held stable while out_valid && !out_ready.
  - On an edge with out_ready: out_valid=0, go to IDLE.
- Latency: acceptance at edge T gives out_valid high in the cycle after edge T+WIDTH, i.e. WIDTH cycles after accept.
- Throughput: one operation per WIDTH+2 cycles minimum.
  - No accept in the same cycle as result handoff; in_ready rises in the cycle after the out_ready handshake.
- Diff/Bout are registered and change only on the DONE-entry edge or on reset.
- Operand changes are ignored outside the acceptance edge.
- in_valid while busy (SHIFT/DONE): ignored; no queueing, no error.
- out_ready while not in DONE: ignored.
- Reset mid-operation (SHIFT or DONE): aborts immediately.
  - out_valid=0 in the cycle after the reset edge; the partial result is discarded.
  - in_ready=1 once rst deasserts.
- Wrap-around: the result is two's-complement modulo 2^WIDTH. Example: 0-1 gives Diff=2^WIDTH-1, Bout=1.
- The bit counter never exceeds WIDTH-1.

Optional Feature:
- Macro: TGFS_SATURATE_EN.
- Defined: on the DONE-entry edge, if the final borrow==1, Diff loads 0 (floor clamp for non-negative membrane potential). Bout still reports 1.
- Undefined: Diff is always the modulo result.
- Latency and handshake are identical in both builds.

Test Plan:
- Basic subtract: A=37, B=12, Bin=0 -> after 10 cycles out_valid=1, Diff=25, Bout=0.
- Underflow: A=12, B=37 -> Diff=999, Bout=1. With TGFS_SATURATE_EN: Diff=0, Bout=1.
- Borrow-in corners:
  - A=0, B=0, Bin=1 -> Diff=1023, Bout=1.
  - A=1023, B=1023, Bin=0 -> Diff=0, Bout=0.
  - A=1023, B=0, Bin=1 -> Diff=1022, Bout=0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> Diff/Bout/out_valid stable. Then out_ready=1 -> out_valid=0 next cycle, in_ready=1.
- Busy ignore: apply a second in_valid (A=5, B=1) during SHIFT cycle 3 of op A=100, B=40 -> only Diff=60 is produced, no second result.
- Reset mid-op: rst=1 for one cycle at SHIFT cycle 4 -> out_valid=0, Diff=0, Bout=0; in_ready=1 after rst drops. Next op A=9, B=4 -> Diff=5.

Source files
------------

// File: rtl/tgfs_serial_10bit.sv
// Bit-serial WIDTH-bit subtractor D = A - B - Bin, one full-subtractor step per clock, LSB first.
// Optional build macro TGFS_SATURATE_EN: clamp Diff to 0 when the final borrow is set.
module tgfs_serial_10bit #(
  parameter int unsigned WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr, res_nx;
  logic             borrow, borrow_nx, d, last;
  logic [CW-1:0]    cnt;

  always_comb begin
    d         = a_sr[0] ^ b_sr[0] ^ borrow;
    borrow_nx = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & borrow);
    res_nx    = {d, res_sr[WIDTH-1:1]};
    last      = (cnt == CW'(WIDTH - 1));
  end

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid && in_ready) state_nx = SHIFT;
      SHIFT:   if (last)                 state_nx = DONE;
      DONE:    if (out_ready)            state_nx = IDLE;
      default:                           state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      Diff   <= '0;
      Bout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_sr   <= A;
            b_sr   <= B;
            borrow <= Bin;
            cnt    <= '0;
          end
        end
        SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_nx;
          borrow <= borrow_nx;
          // counter parks at zero on the final step so it never passes WIDTH-1
          if (last) begin
            cnt  <= '0;
            Bout <= borrow_nx;
`ifdef TGFS_SATURATE_EN
            Diff <= borrow_nx ? '0 : res_nx;
`else
            Diff <= res_nx;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tgfs_serial_10bit.sv
// Directed self-checking bench for tgfs_serial_10bit (WIDTH=10), immediate-assertion style.
module tb_tgfs_serial_10bit;

  localparam int unsigned WIDTH = 10;

  logic             clk = 1'b0;
  logic             rst, in_valid, in_ready, Bin, out_valid, out_ready, Bout;
  logic [WIDTH-1:0] A, B, Diff;

  int compared   = 0;
  int mismatched = 0;

  tgfs_serial_10bit #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Bin(Bin), .out_valid(out_valid), .out_ready(out_ready),
    .Diff(Diff), .Bout(Bout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands for one edge, then scramble them to show they are not re-sampled.
  task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bin);
    chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    A = a; B = b; Bin = bin; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; A = '1; B = 10'h155; Bin = ~bin;
  endtask

  task automatic wait_result(input string tag, input logic [WIDTH-1:0] ed, input logic eb);
    int n;
    n = 0;
    while (!out_valid && n < WIDTH + 6) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, n, WIDTH);
    chk({tag, "_diff"}, {22'd0, Diff}, {22'd0, ed});
    chk({tag, "_bout"}, {31'd0, Bout}, {31'd0, eb});
  endtask

  task automatic handoff(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_ready_back"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; Bin = 1'b0;
    tick(); tick();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_diff", {22'd0, Diff}, 32'd0);
    chk("rst_bout", {31'd0, Bout}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    #1;
    chk("in_ready_after_rst", {31'd0, in_ready}, 32'd1);

    // out_ready in IDLE has no effect
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("idle_out_ready_ignored", {31'd0, out_valid}, 32'd0);

    start_op(10'd37, 10'd12, 1'b0);   wait_result("basic", 10'd25, 1'b0);  handoff("basic");
`ifdef TGFS_SATURATE_EN
    start_op(10'd12, 10'd37, 1'b0);   wait_result("under", 10'd0, 1'b1);   handoff("under");
    start_op(10'd0, 10'd0, 1'b1);     wait_result("zero_bin", 10'd0, 1'b1); handoff("zero_bin");
`else
    start_op(10'd12, 10'd37, 1'b0);   wait_result("under", 10'd999, 1'b1); handoff("under");
    start_op(10'd0, 10'd0, 1'b1);     wait_result("zero_bin", 10'd1023, 1'b1); handoff("zero_bin");
`endif
    start_op(10'd1023, 10'd1023, 1'b0); wait_result("max_eq", 10'd0, 1'b0);    handoff("max_eq");
    start_op(10'd1023, 10'd0, 1'b1);    wait_result("max_bin", 10'd1022, 1'b0); handoff("max_bin");

    // Backpressure: result held stable while out_ready stays low
    start_op(10'd500, 10'd123, 1'b0); wait_result("bp", 10'd377, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_hold_diff", {22'd0, Diff}, 32'd377);
      chk("bp_hold_bout", {31'd0, Bout}, 32'd0);
      chk("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    handoff("bp");

    // Busy ignore: second request during SHIFT is dropped
    start_op(10'd100, 10'd40, 1'b0);
    tick(); tick();
    chk("busy_in_ready", {31'd0, in_ready}, 32'd0);
    A = 10'd5; B = 10'd1; Bin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    begin
      int n;
      n = 0;
      while (!out_valid && n < WIDTH + 6) begin tick(); n++; end
      chk("busy_latency", n, WIDTH - 3);
    end
    chk("busy_diff", {22'd0, Diff}, 32'd60);
    chk("busy_bout", {31'd0, Bout}, 32'd0);
    handoff("busy");
    for (int i = 0; i < WIDTH + 3; i++) begin
      tick();
      chk("busy_no_second", {31'd0, out_valid}, 32'd0);
    end

    // Reset during SHIFT aborts and clears the registered result
    start_op(10'd200, 10'd50, 1'b0);
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_diff", {22'd0, Diff}, 32'd0);
    chk("midrst_bout", {31'd0, Bout}, 32'd0);
    chk("midrst_in_ready_low", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    #1;
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    start_op(10'd9, 10'd4, 1'b0); wait_result("post_rst", 10'd5, 1'b0); handoff("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
